// File: rtl/fir_pkg.sv
// Shared FIR peripheral register map, status bit positions and sequencer state encoding.
package fir_pkg;

    localparam logic [2:0] RegData  = 3'd0;
    localparam logic [2:0] RegStat  = 3'd1;
    localparam logic [2:0] RegCmsb  = 3'd2;
    localparam logic [2:0] RegTaps  = 3'd3;
    localparam logic [2:0] RegBuf   = 3'd4;
    localparam logic [2:0] RegStart = 3'd5;
    localparam logic [2:0] RegArst  = 3'd6;

    localparam int unsigned StatRdy = 0;
    localparam int unsigned StatE   = 1;
    localparam int unsigned StatF   = 2;
    localparam int unsigned StatOvf = 15;

    typedef enum logic [3:0] {
        StIdle,
        StWrData,
        StStart,
        StWait,
        StPoll,
        StPollGap,
        StRead,
        StReadGap,
        StOut
    } state_e;

endpackage

// File: rtl/fir_sequencer.sv
// Drives one FIR peripheral per input sample: write sample, start, wait, poll status,
// then read back cfg_phases+1 results onto the output stream.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 19,
    parameter int unsigned POLL_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cfg_phases,
    input  logic [9:0]  cfg_cbase,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [2:0]  fir_ioaddr,
    output logic        fir_iocs,
    output logic        fir_iowr,
    output logic        fir_iord,
    output logic [15:0] fir_din,
    input  logic [15:0] fir_dout,
    output logic        busy,
    output logic        ovf,
    output logic        timeout
);

    localparam logic [15:0] WaitLd  = 16'(WAIT_CYC);
    localparam logic [15:0] PollLim = 16'(POLL_MAX);

    state_e      r_state, w_state;
    logic [15:0] r_sample, w_sample;
    logic [3:0]  r_phases, w_phases;
    logic [9:0]  r_cbase, w_cbase;
    logic [15:0] r_wait, w_wait;
    logic [15:0] r_polls, w_polls;
    logic [4:0]  r_reads, w_reads;
    logic        r_ovf, w_ovf;
    logic        r_timeout, w_timeout;
    logic [15:0] r_m_data, w_m_data;
    logic        r_m_valid, w_m_valid;
    logic        r_s_ready, w_s_ready;
    logic        r_busy, w_busy;
    logic [2:0]  r_ioaddr, w_ioaddr;
    logic        r_iocs, w_iocs;
    logic        r_iowr, w_iowr;
    logic        r_iord, w_iord;
    logic [15:0] r_din, w_din;

    always_comb begin
        w_state   = r_state;
        w_sample  = r_sample;
        w_phases  = r_phases;
        w_cbase   = r_cbase;
        w_wait    = r_wait;
        w_polls   = r_polls;
        w_reads   = r_reads;
        w_ovf     = r_ovf;
        w_timeout = r_timeout;
        w_m_data  = r_m_data;

        case (r_state)
            StIdle: begin
                if (s_valid && r_s_ready) begin
                    w_sample = s_data;
                    w_phases = cfg_phases;
                    w_cbase  = cfg_cbase;
                    w_polls  = '0;
                    w_reads  = '0;
                    w_state  = StWrData;
                end
            end
            StWrData: w_state = StStart;
            StStart: begin
                w_wait  = WaitLd;
                w_state = (WaitLd == 16'd0) ? StPoll : StWait;
            end
            StWait: begin
                if (r_wait <= 16'd1) begin
                    w_wait  = '0;
                    w_state = StPoll;
                end else begin
                    w_wait = r_wait - 16'd1;
                end
            end
            StPoll: begin
                w_polls = r_polls + 16'd1;
                w_state = StPollGap;
            end
            StPollGap: begin
                if (fir_dout[StatOvf]) w_ovf = 1'b1;
                if (fir_dout[StatRdy]) begin
                    w_state = StRead;
                end else if (r_polls < PollLim) begin
                    w_state = StPoll;
                end else begin
                    // Give up on this sample; it is dropped without output.
                    w_timeout = 1'b1;
                    w_state   = StIdle;
                end
            end
            StRead: begin
                w_reads = r_reads + 5'd1;
                w_state = StReadGap;
            end
            StReadGap: begin
                w_m_data = fir_dout;
                w_state  = StOut;
            end
            StOut: begin
                if (m_ready) begin
                    w_state = (r_reads == ({1'b0, r_phases} + 5'd1)) ? StIdle : StRead;
                end
            end
            default: w_state = StIdle;
        endcase

        // Outputs are decoded from the next state so they can be registered alongside it.
        w_iocs   = 1'b0;
        w_iowr   = 1'b0;
        w_iord   = 1'b0;
        w_ioaddr = 3'd0;
        w_din    = 16'd0;
        case (w_state)
            StWrData: begin
                w_iocs   = 1'b1;
                w_iowr   = 1'b1;
                w_ioaddr = RegData;
                w_din    = w_sample;
            end
            StStart: begin
                w_iocs   = 1'b1;
                w_iowr   = 1'b1;
                w_ioaddr = RegStart;
                w_din    = {6'b0, w_cbase};
            end
            StPoll: begin
                w_iocs   = 1'b1;
                w_iord   = 1'b1;
                w_ioaddr = RegStat;
            end
            StPollGap: begin
                w_iocs   = 1'b1;
                w_ioaddr = RegStat;
            end
            StRead: begin
                w_iocs   = 1'b1;
                w_iord   = 1'b1;
                w_ioaddr = RegData;
            end
            StReadGap: begin
                w_iocs   = 1'b1;
                w_ioaddr = RegData;
            end
            default: ;
        endcase
        w_s_ready = (w_state == StIdle);
        w_busy    = (w_state != StIdle);
        w_m_valid = (w_state == StOut);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_sample  <= '0;
            r_phases  <= '0;
            r_cbase   <= '0;
            r_wait    <= '0;
            r_polls   <= '0;
            r_reads   <= '0;
            r_ovf     <= 1'b0;
            r_timeout <= 1'b0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_ioaddr  <= '0;
            r_iocs    <= 1'b0;
            r_iowr    <= 1'b0;
            r_iord    <= 1'b0;
            r_din     <= '0;
        end else begin
            r_state   <= w_state;
            r_sample  <= w_sample;
            r_phases  <= w_phases;
            r_cbase   <= w_cbase;
            r_wait    <= w_wait;
            r_polls   <= w_polls;
            r_reads   <= w_reads;
            r_ovf     <= w_ovf;
            r_timeout <= w_timeout;
            r_m_data  <= w_m_data;
            r_m_valid <= w_m_valid;
            r_s_ready <= w_s_ready;
            r_busy    <= w_busy;
            r_ioaddr  <= w_ioaddr;
            r_iocs    <= w_iocs;
            r_iowr    <= w_iowr;
            r_iord    <= w_iord;
            r_din     <= w_din;
        end
    end

    assign s_ready    = r_s_ready;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign fir_ioaddr = r_ioaddr;
    assign fir_iocs   = r_iocs;
    assign fir_iowr   = r_iowr;
    assign fir_iord   = r_iord;
    assign fir_din    = r_din;
    assign busy       = r_busy;
    assign ovf        = r_ovf;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: FIR peripheral model, bus/stream monitor, vector table
// plus hand-written backpressure and mid-flight reset sequences.
module tb_fir_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cfg_phases;
    logic [9:0]  cfg_cbase;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [2:0]  fir_ioaddr;
    logic        fir_iocs;
    logic        fir_iowr;
    logic        fir_iord;
    logic [15:0] fir_din;
    logic [15:0] fir_dout;
    logic        busy;
    logic        ovf;
    logic        timeout;

    always #5 clk = ~clk;

    fir_sequencer #(
        .WAIT_CYC(19),
        .POLL_MAX(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_phases(cfg_phases),
        .cfg_cbase (cfg_cbase),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .fir_ioaddr(fir_ioaddr),
        .fir_iocs  (fir_iocs),
        .fir_iowr  (fir_iowr),
        .fir_iord  (fir_iord),
        .fir_din   (fir_din),
        .fir_dout  (fir_dout),
        .busy      (busy),
        .ovf       (ovf),
        .timeout   (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Peripheral model controls (driven from the test process)
    logic        clr;
    int          rdy_after;
    logic        ovf_in;
    logic [15:0] dbase;

    // Model / monitor state
    int          cyc = 0;
    int          npoll_m, nread_m;
    logic        log_wr   [64];
    logic [2:0]  log_addr [64];
    logic [15:0] log_dat  [64];
    int          log_cyc  [64];
    int          log_n;
    logic [15:0] outs     [32];
    int          nout;
    int          acc_cyc, mv_cyc, iocs_cnt;
    int          din_viol = 0;
    int          out_bus_viol = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fir_iocs && fir_iord && fir_ioaddr == 3'd1) begin
            fir_dout <= {ovf_in, 13'b0, !(npoll_m >= rdy_after), (npoll_m >= rdy_after)};
            npoll_m  <= npoll_m + 1;
        end else if (fir_iocs && fir_iord && fir_ioaddr == 3'd0) begin
            fir_dout <= dbase + 16'(nread_m << 12);
            nread_m  <= nread_m + 1;
        end else begin
            fir_dout <= 16'h5A5A;
        end
        if (!fir_iowr && fir_din != 16'd0) din_viol <= din_viol + 1;
        if (m_valid && fir_iocs) out_bus_viol <= out_bus_viol + 1;
        if (clr) begin
            npoll_m  <= 0;
            nread_m  <= 0;
            log_n    <= 0;
            nout     <= 0;
            acc_cyc  <= -1;
            mv_cyc   <= -1;
            iocs_cnt <= 0;
        end else begin
            if (fir_iocs) iocs_cnt <= iocs_cnt + 1;
            if (fir_iocs && (fir_iowr || fir_iord) && log_n < 64) begin
                log_wr[log_n]   <= fir_iowr;
                log_addr[log_n] <= fir_ioaddr;
                log_dat[log_n]  <= fir_din;
                log_cyc[log_n]  <= cyc;
                log_n           <= log_n + 1;
            end
            if (s_valid && s_ready) acc_cyc <= cyc;
            if (m_valid && mv_cyc < 0) mv_cyc <= cyc;
            if (m_valid && m_ready && nout < 32) begin
                outs[nout] <= m_data;
                nout       <= nout + 1;
            end
        end
    end

    typedef struct {
        logic [3:0]  ph;
        logic [9:0]  cb;
        logic [15:0] sd;
        int          ra;
        logic        ov;
        logic [15:0] db;
        int          e_polls;
        int          e_nout;
        int          e_lat;
        int          e_iocs;
        logic        e_ovf;
        logic        e_to;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic check_reset_outs(input string p);
        chk({p, "_sready"}, int'(s_ready), 0);
        chk({p, "_mvalid"}, int'(m_valid), 0);
        chk({p, "_mdata"}, int'(m_data), 0);
        chk({p, "_bus"}, int'({fir_iocs, fir_iowr, fir_iord, fir_ioaddr}), 0);
        chk({p, "_din"}, int'(fir_din), 0);
        chk({p, "_flags"}, int'({busy, ovf, timeout}), 0);
    endtask

    task automatic run_start(input vec_t v, input logic mr);
        rdy_after  = v.ra;
        ovf_in     = v.ov;
        dbase      = v.db;
        cfg_phases = v.ph;
        cfg_cbase  = v.cb;
        m_ready    = mr;
        clr = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        s_data  = v.sd;
        s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (acc_cyc >= 0) break;
        end
        s_valid = 1'b0;
        chk("accept", int'(acc_cyc >= 0), 1);
        chk("busy_after_accept", int'({busy, s_ready}), 2);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (s_ready) break;
            @(negedge clk);
        end
        chk("idle_return", int'(s_ready), 1);
    endtask

    task automatic check_vec(input vec_t v);
        int np, nr, first_poll, prev_poll, bad_gap, kind;
        np = 0; nr = 0; first_poll = -1; prev_poll = -1; bad_gap = 0;
        for (int i = 2; i < log_n && i < 64; i++) begin
            kind = (log_wr[i] ? 8 : 0) + int'(log_addr[i]);
            if (kind == 1) begin
                if (first_poll < 0) first_poll = log_cyc[i];
                else if (log_cyc[i] - prev_poll != 2) bad_gap++;
                prev_poll = log_cyc[i];
                np++;
            end else if (kind == 0) begin
                nr++;
            end else begin
                bad_gap++;
            end
        end
        chk("w0_kind", (log_wr[0] ? 8 : 0) + int'(log_addr[0]), 8);
        chk("w0_data", int'(log_dat[0]), int'(v.sd));
        chk("w0_timing", log_cyc[0] - acc_cyc, 1);
        chk("w5_kind", (log_wr[1] ? 8 : 0) + int'(log_addr[1]), 13);
        chk("w5_data", int'(log_dat[1]), int'(v.cb));
        chk("wait_gap", first_poll - log_cyc[1], 20);
        chk("poll_count", np, v.e_polls);
        chk("poll_spacing", bad_gap, 0);
        chk("data_reads", nr, v.e_nout);
        chk("out_count", nout, v.e_nout);
        for (int k = 0; k < v.e_nout; k++)
            chk("out_value", int'(outs[k]), int'(v.db + 16'(k << 12)));
        if (v.e_lat >= 0) chk("latency", mv_cyc - acc_cyc - 1, v.e_lat);
        else chk("no_mvalid", mv_cyc, -1);
        chk("iocs_cycles", iocs_cnt, v.e_iocs);
        chk("ovf", int'(ovf), int'(v.e_ovf));
        chk("timeout", int'(timeout), int'(v.e_to));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d0;
        int nbad_d, nbad_bus;
        vec_t vr;

        vt[0] = '{4'd0,  10'd0,     16'd16384, 0,  1'b0, 16'h1234, 1, 1, 25, 6,  1'b0, 1'b0};
        vt[1] = '{4'd3,  10'h2A5,   16'h8001,  0,  1'b0, 16'h1000, 1, 4, 25, 12, 1'b0, 1'b0};
        vt[2] = '{4'd0,  10'h3FF,   16'h00FF,  3,  1'b0, 16'h0777, 4, 1, 31, 12, 1'b0, 1'b0};
        vt[3] = '{4'd1,  10'h001,   16'h7FFF,  0,  1'b1, 16'hBEEF, 1, 2, 25, 8,  1'b1, 1'b0};
        vt[4] = '{4'd15, 10'h155,   16'h0042,  99, 1'b0, 16'h0000, 4, 0, -1, 10, 1'b1, 1'b1};

        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; clr = 1'b1;
        cfg_phases = '0; cfg_cbase = '0; rdy_after = 0; ovf_in = 1'b0; dbase = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("por");
        clr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("por_sready_after_release", int'(s_ready), 1);

        for (int i = 0; i < 5; i++) begin
            run_start(vt[i], 1'b1);
            wait_idle();
            check_vec(vt[i]);
        end

        // Backpressure: hold m_ready low in OUT
        vr = '{4'd1, 10'h0AA, 16'h0123, 0, 1'b0, 16'h0C00, 1, 2, 25, 8, 1'b1, 1'b1};
        run_start(vr, 1'b0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        chk("bp_mvalid", int'(m_valid), 1);
        d0 = m_data;
        chk("bp_data0", int'(d0), 16'h0C00);
        nbad_d = 0; nbad_bus = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_data !== d0 || !m_valid) nbad_d++;
            if (fir_iocs) nbad_bus++;
        end
        chk("bp_stable", nbad_d, 0);
        chk("bp_no_bus", nbad_bus, 0);
        m_ready = 1'b1;
        wait_idle();
        chk("bp_out_count", nout, 2);
        chk("bp_out1", int'(outs[1]), 16'h1C00);
        chk("bp_sticky", int'({ovf, timeout}), 3);

        // Reset while waiting; sample must be discarded
        vr = '{4'd0, 10'h011, 16'h1111, 0, 1'b0, 16'h2222, 1, 1, 25, 6, 1'b0, 1'b0};
        run_start(vr, 1'b1);
        repeat (8) @(negedge clk);
        chk("wait_busy_idle_bus", int'({busy, fir_iocs}), 2);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outs("mid_rst");
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sready_after_release", int'(s_ready), 1);
        vr = '{4'd0, 10'h0F0, 16'h0ABC, 0, 1'b0, 16'h3333, 1, 1, 25, 6, 1'b0, 1'b0};
        run_start(vr, 1'b1);
        wait_idle();
        check_vec(vr);

        chk("din_zero_when_not_writing", din_viol, 0);
        chk("no_bus_in_out", out_bus_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
